trans_sid_alloc_ipa: RTL
========================

Name: trans_sid_alloc_ipa

Overview:
Allocates and recycles DMA transaction IDs (TRANS_SID) among the cluster cores. It arbitrates core allocation requests round-robin and hands out the lowest free ID. Each ID is tracked through its lifetime using the per-ID trans_status outputs of the synchronization units. An ID returns to the free pool only after its owner has released it and its synch unit reports no outstanding traffic.

Parameters:
NB_CORES, 4, number of requesting cores
NB_TRANSFERS, 4, number of transaction IDs / synch units (power of 2)
TRANS_SID_WIDTH, 2, width of an ID; equals log2(NB_TRANSFERS)

Ports:
clk_i  input  1  clock
rst_ni  input  1  reset, asynchronous, active-low
alloc_req_i  input  NB_CORES  per-core ID allocation request (level, held until granted)
alloc_gnt_o  output  NB_CORES  one-hot grant, combinational, same cycle as accepted request
alloc_sid_o  output  TRANS_SID_WIDTH  allocated ID, valid while any alloc_gnt_o bit is high
free_req_i  input  NB_CORES  per-core ID release pulse
free_sid_i  input  NB_CORES*TRANS_SID_WIDTH  ID being released, per core
trans_status_i  input  NB_TRANSFERS  per-ID busy from synch units (1 = outstanding commands)
sid_busy_o  output  NB_TRANSFERS  per-ID state != FREE, registered
nb_free_o  output  TRANS_SID_WIDTH+1  count of FREE IDs, registered
full_o  output  1  no FREE ID (nb_free_o == 0)
err_o  output  1  illegal-release pulse (see Optional Feature)

Behaviour:
- Per-ID 2-bit state: FREE, ALLOC, DRAIN. Reset: all FREE, RR pointer 0, sid_busy_o = 0, nb_free_o = NB_TRANSFERS, full_o = 0, alloc_gnt_o = 0, err_o = 0.
- Grant (comb):
  - If at least one ID is FREE and at least one alloc_req_i is set, exactly one core is granted.
  - The winner is the first requester at or after the RR pointer, wrapping at NB_CORES.
  - alloc_sid_o is the lowest-index FREE ID.
  - Otherwise alloc_gnt_o = 0 and alloc_sid_o = 0.
- Grant (clocked): on a grant, that ID goes FREE->ALLOC at the next edge and the RR pointer moves to winner+1 mod NB_CORES. The pointer is unchanged when there is no grant.
- Release: free_req_i[c] with free_sid_i[c] = k, where ID k is in ALLOC:
  - trans_status_i[k] = 1 -> ALLOC->DRAIN.
  - trans_status_i[k] = 0 -> ALLOC->FREE directly.
- DRAIN->FREE on the first edge where trans_status_i[k] = 0. The synch unit's status stretch already covers the final-command cycle; no additional delay is added.
- A release of an ID in FREE or DRAIN is ignored; the state is unchanged.
- Simultaneous events:
  - Multiple cores releasing different IDs in one cycle: all are processed.
  - Two cores releasing the same ID in one cycle: a single transition.
  - An ID freed in cycle t is grantable from cycle t+1 only. Grant selection uses pre-edge state.
  - A release targeting the ID being granted in the same cycle is impossible (that ID is FREE), so it is ignored.
- nb_free_o and sid_busy_o are computed from the next-state and registered, so they reflect the post-edge state. full_o = (nb_free_o == 0).
- Requests while full_o = 1 stall with no grant. Fairness is preserved via the RR pointer.
- Async reset mid-operation immediately forces all state FREE and drops all grants. In-flight synch-unit traffic is not tracked after reset.

Optional Feature:
Macro TRANS_SID_OWNER_CHECK_EN.
- Defined:
  - A per-ID owner register (core index) is written at grant.
  - A release is honoured only if the releasing core equals the owner and the ID is in ALLOC.
  - Any other release (wrong owner, FREE or DRAIN ID) is ignored and err_o pulses high for one cycle, registered, the cycle after the offending request.
- Undefined: no owner storage; any core may release any ALLOC ID; err_o tied 0.

Test Plan:
- Reset, no requests -> nb_free_o=4, full_o=0, sid_busy_o=0000, alloc_gnt_o=0.
- Cores 0..3 all request in cycle 0, held -> grants 0001, 0010, 0100, 1000 in consecutive cycles with alloc_sid_o 0,1,2,3; then full_o=1 and nb_free_o=0.
- Full pool, core 2 requests; core 1 frees ID 1 with trans_status_i[1]=0 -> ID 1 FREE next edge; core 2 granted ID 1 one cycle later, not in the free cycle.
- Free ID 0 while trans_status_i[0]=1 held 5 cycles -> sid_busy_o[0] stays 1 (DRAIN), nb_free_o unchanged; ID 0 becomes FREE on the edge after trans_status_i[0] falls.
- RR fairness: cores 0 and 3 request continuously with free IDs recycled every cycle -> grants alternate 0,3,0,3.
- With TRANS_SID_OWNER_CHECK_EN: core 1 frees ID owned by core 0 -> state unchanged, err_o=1 one cycle later; core 0 then frees it -> accepted, err_o=0.

Source files
------------

// File: rtl/trans_sid_alloc_ipa.sv
// DMA transaction-ID allocator: round-robin core grant, lowest-free-ID pick, release/drain recycling.
// Optional owner check on release enabled by defining TRANS_SID_OWNER_CHECK_EN.
`timescale 1ns/1ps
module trans_sid_alloc_ipa #(
  parameter int NB_CORES        = 4,
  parameter int NB_TRANSFERS    = 4,
  parameter int TRANS_SID_WIDTH = 2
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NB_CORES-1:0]                 alloc_req_i,
  output logic [NB_CORES-1:0]                 alloc_gnt_o,
  output logic [TRANS_SID_WIDTH-1:0]          alloc_sid_o,
  input  logic [NB_CORES-1:0]                 free_req_i,
  input  logic [NB_CORES*TRANS_SID_WIDTH-1:0] free_sid_i,
  input  logic [NB_TRANSFERS-1:0]             trans_status_i,
  output logic [NB_TRANSFERS-1:0]             sid_busy_o,
  output logic [TRANS_SID_WIDTH:0]            nb_free_o,
  output logic                                full_o,
  output logic                                err_o
);

  localparam int CW = (NB_CORES > 1) ? $clog2(NB_CORES) : 1;

  typedef enum logic [1:0] {S_FREE = 2'd0, S_ALLOC = 2'd1, S_DRAIN = 2'd2} sid_state_e;

  sid_state_e                 st_q [NB_TRANSFERS];
  sid_state_e                 st_d [NB_TRANSFERS];
  logic [CW-1:0]              rr_q, rr_d, winner;
  logic                       found, any_free, rel_ok;
  logic [TRANS_SID_WIDTH-1:0] low_free, rel;
  logic [NB_TRANSFERS-1:0]    busy_d;
  logic [TRANS_SID_WIDTH:0]   nb_d;
`ifdef TRANS_SID_OWNER_CHECK_EN
  logic [CW-1:0]              owner_q [NB_TRANSFERS];
  logic                       err_d, err_q;
`endif

  // Grant selection works purely on pre-edge state.
  always_comb begin
    any_free = 1'b0;
    low_free = '0;
    for (int k = NB_TRANSFERS-1; k >= 0; k--) begin
      if (st_q[k] == S_FREE) begin
        any_free = 1'b1;
        low_free = TRANS_SID_WIDTH'(k);
      end
    end
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < NB_CORES; i++) begin
      if (!found && alloc_req_i[(int'(rr_q) + i) % NB_CORES]) begin
        found  = 1'b1;
        winner = CW'((int'(rr_q) + i) % NB_CORES);
      end
    end
    alloc_gnt_o = '0;
    alloc_sid_o = '0;
    rr_d        = rr_q;
    if (found && any_free && rst_ni) begin
      alloc_gnt_o[winner] = 1'b1;
      alloc_sid_o         = low_free;
      rr_d = (int'(winner) == NB_CORES-1) ? '0 : winner + CW'(1);
    end
  end

  always_comb begin
    st_d   = st_q;
    rel    = '0;
    rel_ok = 1'b0;
`ifdef TRANS_SID_OWNER_CHECK_EN
    err_d  = 1'b0;
`endif
    for (int k = 0; k < NB_TRANSFERS; k++) begin
      if (st_q[k] == S_DRAIN && !trans_status_i[k]) st_d[k] = S_FREE;
    end
    for (int c = 0; c < NB_CORES; c++) begin
      if (free_req_i[c]) begin
        rel    = free_sid_i[c*TRANS_SID_WIDTH +: TRANS_SID_WIDTH];
        rel_ok = (st_q[rel] == S_ALLOC);
`ifdef TRANS_SID_OWNER_CHECK_EN
        rel_ok = rel_ok && (owner_q[rel] == CW'(c));
        if (!rel_ok) err_d = 1'b1;
`endif
        if (rel_ok) st_d[rel] = trans_status_i[rel] ? S_DRAIN : S_FREE;
      end
    end
    if (alloc_gnt_o != '0) st_d[low_free] = S_ALLOC;
    busy_d = '0;
    nb_d   = '0;
    for (int k = 0; k < NB_TRANSFERS; k++) begin
      if (st_d[k] == S_FREE) nb_d = nb_d + (TRANS_SID_WIDTH+1)'(1);
      else                   busy_d[k] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NB_TRANSFERS; k++) st_q[k] <= S_FREE;
      rr_q       <= '0;
      sid_busy_o <= '0;
      nb_free_o  <= (TRANS_SID_WIDTH+1)'(NB_TRANSFERS);
    end else begin
      st_q       <= st_d;
      rr_q       <= rr_d;
      sid_busy_o <= busy_d;
      nb_free_o  <= nb_d;
    end
  end

  assign full_o = (nb_free_o == '0);

`ifdef TRANS_SID_OWNER_CHECK_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NB_TRANSFERS; k++) owner_q[k] <= '0;
      err_q <= 1'b0;
    end else begin
      if (alloc_gnt_o != '0) owner_q[low_free] <= winner;
      err_q <= err_d;
    end
  end
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule
